// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one single-ported memory bus between instruction fetch
// and the memory-stage load/store port; mem has priority, with a starvation guard for fetch.
module mem_arbiter #(
  parameter int unsigned MEM_MAX_CONSEC = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        fe_req,
  input  logic [29:0] fe_addr,
  output logic        fe_ack,
  output logic        fe_error,
  output logic [31:0] fe_data,

  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic        mem_extend,
  input  logic [1:0]  mem_width,
  output logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata,

  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  output logic        bus_extend,
  output logic [1:0]  bus_width,
  input  logic        bus_ack,
  input  logic        bus_error,
  input  logic [31:0] bus_rdata,

  output logic [1:0]  arb_owner
);

  localparam int unsigned STARVE_W = 8;
  localparam int unsigned TO_W     = 16;

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MEM_MAX_CONSEC);
  localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT - 32'd1);
  localparam bit                  TO_EN      = (TIMEOUT != 0);

  // State encoding doubles as the arb_owner status value.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FE_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [TO_W-1:0]     to_cnt;

  logic busy;
  logic fe_force;
  logic grant_fe;
  logic grant_mem;
  logic timeout_hit;

  assign busy        = (state != IDLE);
  assign fe_force    = fe_req && (starve_cnt == STARVE_MAX);
  assign timeout_hit = TO_EN && busy && !bus_ack && (to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and grant decisions.
  always_comb begin
    state_nxt = state;
    grant_fe  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && !fe_force) begin
          grant_mem = 1'b1;
          state_nxt = MEM_BUSY;
        end else if (fe_req) begin
          grant_fe  = 1'b1;
          state_nxt = FE_BUSY;
        end
      end
      FE_BUSY, MEM_BUSY: begin
        if (bus_ack || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Starvation guard: counts mem grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_fe) begin
      starve_cnt <= '0;
    end else if (grant_mem) begin
      if (!fe_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt < STARVE_MAX) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

  // Busy-cycle counter for the bus timeout; saturates when timeout is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (grant_fe || grant_mem) begin
      to_cnt <= '0;
    end else if (busy && !bus_ack && (to_cnt != {TO_W{1'b1}})) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Bus mux and completion routing from the current owner.
  always_comb begin
    bus_req    = 1'b0;
    bus_addr   = '0;
    bus_write  = 1'b0;
    bus_wdata  = '0;
    bus_extend = 1'b0;
    bus_width  = 2'd0;
    fe_ack     = 1'b0;
    fe_error   = 1'b0;
    fe_data    = '0;
    mem_ack    = 1'b0;
    mem_error  = 1'b0;
    mem_rdata  = '0;
    arb_owner  = state;
    case (state)
      FE_BUSY: begin
        bus_req   = 1'b1;
        bus_addr  = {fe_addr, 2'b00};
        bus_width = 2'd2;
        if (bus_ack) begin
          fe_ack   = 1'b1;
          fe_error = bus_error;
          fe_data  = bus_rdata;
        end else if (timeout_hit) begin
          fe_ack   = 1'b1;
          fe_error = 1'b1;
        end
      end
      MEM_BUSY: begin
        bus_req    = 1'b1;
        bus_addr   = mem_addr;
        bus_write  = mem_write;
        bus_wdata  = mem_wdata;
        bus_extend = mem_extend;
        bus_width  = mem_width;
        if (bus_ack) begin
          mem_ack   = 1'b1;
          mem_error = bus_error;
          mem_rdata = bus_rdata;
        end else if (timeout_hit) begin
          mem_ack   = 1'b1;
          mem_error = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, priority, starvation guard, timeout, bus error, reset.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        fe_req;
  logic [29:0] fe_addr;
  logic        fe_ack;
  logic        fe_error;
  logic [31:0] fe_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        mem_extend;
  logic [1:0]  mem_width;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic        bus_extend;
  logic [1:0]  bus_width;
  logic        bus_ack;
  logic        bus_error;
  logic [31:0] bus_rdata;
  logic [1:0]  arb_owner;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.MEM_MAX_CONSEC(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_error(fe_error), .fe_data(fe_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_extend(mem_extend), .mem_width(mem_width), .mem_ack(mem_ack), .mem_error(mem_error),
    .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write), .bus_wdata(bus_wdata),
    .bus_extend(bus_extend), .bus_width(bus_width), .bus_ack(bus_ack), .bus_error(bus_error),
    .bus_rdata(bus_rdata), .arb_owner(arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  logic [1:0] seq [10];
  int         ng;

  initial begin
    reset_n = 1'b0;
    fe_req = 1'b0; fe_addr = '0;
    mem_req = 1'b0; mem_addr = '0; mem_write = 1'b0; mem_wdata = '0;
    mem_extend = 1'b0; mem_width = 2'd0;
    bus_ack = 1'b0; bus_error = 1'b0; bus_rdata = '0;
    for (int i = 0; i < 10; i++) seq[i] = 2'd0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_owner", 32'(arb_owner), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_fe_ack", 32'(fe_ack), 32'd0);
    check("rst_mem_ack", 32'(mem_ack), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fetch read, ack in busy cycle 2
    @(negedge clk);
    fe_req = 1'b1; fe_addr = 30'h40;
    @(negedge clk); #1;
    check("s1_owner", 32'(arb_owner), 32'd1);
    check("s1_bus_req", 32'(bus_req), 32'd1);
    check("s1_bus_addr", bus_addr, 32'h100);
    check("s1_bus_width", 32'(bus_width), 32'd2);
    check("s1_bus_write", 32'(bus_write), 32'd0);
    check("s1_early_ack", 32'(fe_ack), 32'd0);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h13; #1;
    check("s1_fe_ack", 32'(fe_ack), 32'd1);
    check("s1_fe_data", fe_data, 32'h13);
    check("s1_fe_error", 32'(fe_error), 32'd0);
    check("s1_mem_ack", 32'(mem_ack), 32'd0);
    @(negedge clk);
    fe_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0; #1;
    check("s1_idle_owner", 32'(arb_owner), 32'd0);
    check("s1_idle_ack", 32'(fe_ack), 32'd0);

    // Simultaneous requests: mem store wins, fetch follows after one idle cycle
    @(negedge clk);
    fe_req = 1'b1; fe_addr = 30'h80;
    mem_req = 1'b1; mem_addr = 32'h200; mem_write = 1'b1; mem_wdata = 32'hDEADBEEF; mem_width = 2'd2;
    @(negedge clk); #1;
    check("s2_owner_mem", 32'(arb_owner), 32'd2);
    check("s2_bus_write", 32'(bus_write), 32'd1);
    check("s2_bus_wdata", bus_wdata, 32'hDEADBEEF);
    check("s2_bus_addr", bus_addr, 32'h200);
    bus_ack = 1'b1; #1;
    check("s2_mem_ack", 32'(mem_ack), 32'd1);
    check("s2_fe_ack_low", 32'(fe_ack), 32'd0);
    @(negedge clk);
    mem_req = 1'b0; mem_write = 1'b0; mem_wdata = '0; bus_ack = 1'b0; #1;
    check("s2_idle_gap", 32'(arb_owner), 32'd0);
    @(negedge clk); #1;
    check("s2_owner_fe", 32'(arb_owner), 32'd1);
    check("s2_fe_bus_addr", bus_addr, 32'h200);
    bus_ack = 1'b1; #1;
    check("s2_fe_ack", 32'(fe_ack), 32'd1);
    @(negedge clk);
    fe_req = 1'b0; bus_ack = 1'b0;

    // Starvation guard: fetch held while mem requests back to back
    @(negedge clk);
    fe_req = 1'b1; fe_addr = 30'h11;
    mem_req = 1'b1; mem_addr = 32'h400; mem_write = 1'b0; mem_width = 2'd2;
    ng = 0;
    for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
      @(negedge clk);
      bus_ack = (arb_owner != 2'd0);
      #1;
      if (arb_owner != 2'd0) begin
        seq[ng] = arb_owner;
        ng++;
      end
    end
    @(negedge clk);
    fe_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
    check("s3_grant_count", 32'(ng), 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("s3_grant%0d", i), 32'(seq[i]), (i % 5 == 4) ? 32'd1 : 32'd2);

    // Timeout on a mem load, then a late ack in idle
    @(negedge clk);
    mem_req = 1'b1; mem_addr = 32'h300; mem_write = 1'b0; mem_width = 2'd1; mem_extend = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        check("s4_bus_extend", 32'(bus_extend), 32'd1);
        check("s4_bus_width", 32'(bus_width), 32'd1);
      end
      if (k < 8) begin
        check($sformatf("s4_no_ack_c%0d", k), 32'(mem_ack), 32'd0);
      end else begin
        check("s4_to_ack", 32'(mem_ack), 32'd1);
        check("s4_to_error", 32'(mem_error), 32'd1);
        check("s4_to_rdata", mem_rdata, 32'd0);
      end
    end
    @(negedge clk);
    mem_req = 1'b0; mem_extend = 1'b0; mem_width = 2'd0; #1;
    check("s4_idle", 32'(arb_owner), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h55; #1;
    check("s4_late_mem_ack", 32'(mem_ack), 32'd0);
    check("s4_late_fe_ack", 32'(fe_ack), 32'd0);
    check("s4_late_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = '0;

    // Bus error on a fetch
    @(negedge clk);
    fe_req = 1'b1; fe_addr = 30'h10;
    @(negedge clk);
    bus_ack = 1'b1; bus_error = 1'b1; bus_rdata = 32'hAAAA; #1;
    check("s5_fe_ack", 32'(fe_ack), 32'd1);
    check("s5_fe_error", 32'(fe_error), 32'd1);
    check("s5_fe_data", fe_data, 32'hAAAA);
    check("s5_mem_ack", 32'(mem_ack), 32'd0);
    @(negedge clk);
    fe_req = 1'b0; bus_ack = 1'b0; bus_error = 1'b0; bus_rdata = '0;

    // Reset while MEM_BUSY drops the transaction immediately
    @(negedge clk);
    mem_req = 1'b1; mem_write = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h1234; mem_width = 2'd2;
    @(negedge clk); #1;
    check("s6_owner_mem", 32'(arb_owner), 32'd2);
    check("s6_bus_req", 32'(bus_req), 32'd1);
    #2;
    reset_n = 1'b0; bus_ack = 1'b1; #1;
    check("s6_rst_bus_req", 32'(bus_req), 32'd0);
    check("s6_rst_mem_ack", 32'(mem_ack), 32'd0);
    check("s6_rst_owner", 32'(arb_owner), 32'd0);
    @(negedge clk);
    mem_req = 1'b0; mem_write = 1'b0; bus_ack = 1'b0; reset_n = 1'b1;
    @(negedge clk); #1;
    check("s6_post_owner", 32'(arb_owner), 32'd0);
    check("s6_post_bus_req", 32'(bus_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported memory bus between the fetch port and the memory-stage load/store port of the pipeline. Each transaction is granted to one requester, held until the bus acknowledges or a timeout expires, and then returned to idle. The memory stage has priority, with a starvation guard for fetch. The block sits between the two pipeline memory ports and the memory model/bus, and is transparent to the existing req/ack protocol.

## Interface

Parameters:
- MEM_MAX_CONSEC, 4: maximum consecutive mem grants while fe_req is pending before fe is forced a grant (range 1–255).
- TIMEOUT, 255: busy cycles without bus_ack before error completion; 0 disables timeout (range 0–65535).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fe_req  in  1  fetch request; held until fe_ack.
- fe_addr  in  30  fetch word address [31:2].
- fe_ack  out  1  one-cycle completion pulse to fetch.
- fe_error  out  1  fetch error; valid with fe_ack.
- fe_data  out  32  fetch read data; valid with fe_ack.
- mem_req  in  1  mem-stage request; held until mem_ack.
- mem_addr  in  32  byte address.
- mem_write  in  1  1 = store, 0 = load.
- mem_wdata  in  32  store data.
- mem_extend  in  1  sign-extend load.
- mem_width  in  2  0 = byte, 1 = half, 2 = word.
- mem_ack  out  1  one-cycle completion pulse to mem stage.
- mem_error  out  1  error; valid with mem_ack.
- mem_rdata  out  32  load data; valid with mem_ack.
- bus_req  out  1  request to memory.
- bus_addr  out  32  byte address.
- bus_write  out  1  store strobe.
- bus_wdata  out  32  store data.
- bus_extend  out  1  sign-extend.
- bus_width  out  2  access width.
- bus_ack  in  1  memory completion pulse.
- bus_error  in  1  memory error; valid with bus_ack.
- bus_rdata  in  32  memory read data; valid with bus_ack.
- arb_owner  out  2  0 = idle, 1 = fe, 2 = mem (debug/status).

## Operation

- Requester contract: once asserted, req and its attributes stay stable until ack. The arbiter never aborts a granted transaction. If req drops mid-transaction, the transaction still completes and ack is still pulsed.
- FSM states: IDLE, FE_BUSY, MEM_BUSY.
- IDLE transitions:
  - mem_req && !(fe_req && starve_cnt == MEM_MAX_CONSEC) → MEM_BUSY.
  - else fe_req → FE_BUSY.
  - else stay in IDLE.
- FE_BUSY / MEM_BUSY: exit to IDLE on bus_ack, or on timeout (to_cnt == TIMEOUT−1 with no bus_ack, TIMEOUT ≠ 0).
- Busy-state outputs (registered state, combinational mux from the owner's inputs):
  - bus_req = 1.
  - FE_BUSY: bus_addr = {fe_addr, 2'b00}, bus_write = 0, bus_wdata = 0, bus_extend = 0, bus_width = 2.
  - MEM_BUSY: bus fields = mem_* fields.
- IDLE outputs: bus_req = 0 and all bus fields = 0.
- Completion:
  - Owner ack = bus_ack & (state == owner); error = bus_error; data = bus_rdata.
  - The non-owner ack is 0. Data/error outputs are 0 when their ack is 0.
  - bus_ack in IDLE (e.g. a late ack after timeout) is ignored.
- Timeout completion: owner ack = 1, error = 1, data = 0 for one cycle; state → IDLE.
- starve_cnt (8-bit):
  - Increment (saturating at MEM_MAX_CONSEC) on each mem grant made while fe_req = 1.
  - Clear on any fe grant.
  - Clear on a mem grant made while fe_req = 0.
- to_cnt (16-bit): cleared on every grant; increments each busy cycle without bus_ack.
- Simultaneous fe_req and mem_req in IDLE: mem wins unless starve_cnt == MEM_MAX_CONSEC.

## Timing

- Reset values: state IDLE; bus_req 0; all bus fields 0; fe_ack, mem_ack, errors, and data 0; arb_owner 0; starve_cnt 0; to_cnt 0.
- Grant latency:
  - req sampled in IDLE at edge N → bus_req high in cycle N+1.
  - Ack is combinational in the cycle bus_ack is high.
  - State returns to IDLE at the following edge.
- At least one IDLE cycle separates any two transactions. Minimum transaction occupancy is 2 cycles (grant + ack) plus 1 idle cycle.
- Zero-wait memory (bus_ack in the first busy cycle): ack is seen 1 cycle after the request is sampled.
- Timeout: error ack occurs in busy cycle TIMEOUT (counting from 1) if no bus_ack arrives before then. If bus_ack and timeout coincide, bus_ack wins with bus_error/bus_rdata.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight transaction is dropped and no ack is issued.

## Test plan

- Reset, then fe_req with fe_addr = 0x0000_0040 and memory ack after 2 cycles with rdata 0x0000_0013 → bus_addr = 0x0000_0100, bus_width = 2, bus_write = 0; fe_ack pulse with fe_data = 0x13; arb_owner 1 → 0.
- fe_req and mem_req raised in the same cycle, mem store to 0x200 with wdata 0xDEADBEEF, width 2 → mem granted first (bus_write = 1, bus_wdata = 0xDEADBEEF); fe granted after mem_ack plus 1 idle cycle.
- fe_req held high with back-to-back mem_req, MEM_MAX_CONSEC = 4 → exactly 4 mem grants, then 1 fe grant, then the mem grant count restarts.
- TIMEOUT = 8, mem load with no bus_ack → mem_ack = 1, mem_error = 1, mem_rdata = 0 in busy cycle 8. A late bus_ack while IDLE produces no ack.
- Memory returns bus_error = 1 on a fe transaction → fe_ack = 1, fe_error = 1; mem_ack stays 0.
- reset_n asserted while MEM_BUSY → bus_req drops to 0 asynchronously, no mem_ack, and the FSM is in IDLE after release.
